// File: rtl/keypad_entry_if.sv
// Keypad entry bus: decoded key input from the keypad decoder, and the
// strobe/value/operand outputs toward the display and calculator datapath.
interface keypad_if #(
    parameter int NUM_DIGITS = 4
);
    logic [3:0]              key_code;
    logic                    key_down;
    logic                    key_strobe;
    logic [3:0]              key_val;
    logic [4*NUM_DIGITS-1:0] entry;
    logic [2:0]              digit_count;
    logic                    op_strobe;
    logic [1:0]              op_code;
    logic [4*NUM_DIGITS-1:0] operand;

    // Upstream side: drives the decoded key, observes the results
    modport master (
        output key_code, key_down,
        input  key_strobe, key_val, entry, digit_count, op_strobe, op_code, operand
    );

    // keypad_entry side
    modport slave (
        input  key_code, key_down,
        output key_strobe, key_val, entry, digit_count, op_strobe, op_code, operand
    );
endinterface

// File: rtl/keypad_entry.sv
// Keypad entry: synchronises and debounces the decoded key, emits one strobe
// per physical press, and accumulates a BCD operand with clear/backspace and
// operator capture.
module keypad_entry #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NUM_DIGITS      = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    keypad_if.slave  bus
);
    localparam int              EW       = 4 * NUM_DIGITS;
    localparam int              CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // The IDLE cycle that first sees kd_s high counts as the first stable
    // sample, so the DB_* states terminate one count early. This makes the
    // press latency exactly 2 sync flops + DEBOUNCE_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [2:0]       DIG_MAX  = 3'(NUM_DIGITS);

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        DB_PRESS   = 2'b01,
        PRESSED    = 2'b10,
        DB_RELEASE = 2'b11
    } state_t;

    logic             kd_m_q, kd_s_q;
    logic [3:0]       kc_m_q, kc_s_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    logic             key_strobe_q, key_strobe_d;
    logic [3:0]       key_val_q, key_val_d;
    logic [EW-1:0]    entry_q, entry_d;
    logic [2:0]       digit_count_q, digit_count_d;
    logic             op_strobe_q, op_strobe_d;
    logic [1:0]       op_code_q, op_code_d;
    logic [EW-1:0]    operand_q, operand_d;

    // Two-flop synchronisers for the asynchronous decoder outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kd_m_q <= 1'b0;
            kd_s_q <= 1'b0;
            kc_m_q <= 4'h0;
            kc_s_q <= 4'h0;
        end else begin
            kd_m_q <= bus.key_down;
            kd_s_q <= kd_m_q;
            kc_m_q <= bus.key_code;
            kc_s_q <= kc_m_q;
        end
    end

    // Debounce FSM state and counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Debounce next state; accept marks the single cycle a press is taken
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (kd_s_q) begin
                    state_d = DB_PRESS;
                    cnt_d   = '0;
                end
            end
            DB_PRESS: begin
                if (!kd_s_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!kd_s_q) begin
                    state_d = DB_RELEASE;
                    cnt_d   = '0;
                end
            end
            DB_RELEASE: begin
                if (kd_s_q) begin
                    // Bounce during release: still the same press, no new strobe
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Entry/operand update on an accepted press; strobes are single-cycle
    always_comb begin
        key_strobe_d  = accept;
        op_strobe_d   = 1'b0;
        key_val_d     = key_val_q;
        entry_d       = entry_q;
        digit_count_d = digit_count_q;
        op_code_d     = op_code_q;
        operand_d     = operand_q;
        if (accept) begin
            key_val_d = kc_s_q;
            if (kc_s_q <= 4'h9) begin
                // Full register ignores further digits rather than wrapping
                if (digit_count_q < DIG_MAX) begin
                    entry_d       = {entry_q[EW-5:0], kc_s_q};
                    digit_count_d = digit_count_q + 3'd1;
                end
            end else if (kc_s_q == 4'hA) begin
                entry_d       = '0;
                digit_count_d = 3'd0;
            end else if (kc_s_q == 4'hB) begin
                if (digit_count_q != 3'd0) begin
                    entry_d       = {4'h0, entry_q[EW-1:4]};
                    digit_count_d = digit_count_q - 3'd1;
                end
            end else begin
                operand_d     = entry_q;
                op_code_d     = kc_s_q[1:0];
                op_strobe_d   = 1'b1;
                entry_d       = '0;
                digit_count_d = 3'd0;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_strobe_q  <= 1'b0;
            key_val_q     <= 4'h0;
            entry_q       <= '0;
            digit_count_q <= 3'd0;
            op_strobe_q   <= 1'b0;
            op_code_q     <= 2'b00;
            operand_q     <= '0;
        end else begin
            key_strobe_q  <= key_strobe_d;
            key_val_q     <= key_val_d;
            entry_q       <= entry_d;
            digit_count_q <= digit_count_d;
            op_strobe_q   <= op_strobe_d;
            op_code_q     <= op_code_d;
            operand_q     <= operand_d;
        end
    end

    assign bus.key_strobe  = key_strobe_q;
    assign bus.key_val     = key_val_q;
    assign bus.entry       = entry_q;
    assign bus.digit_count = digit_count_q;
    assign bus.op_strobe   = op_strobe_q;
    assign bus.op_code     = op_code_q;
    assign bus.operand     = operand_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with DEBOUNCE_CYCLES=4.
module tb_keypad_entry;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    int   ks_cnt, os_cnt, ks_wide, os_wide;
    logic ks_prev, os_prev;

    keypad_if #(.NUM_DIGITS(4)) bus ();

    keypad_entry #(.DEBOUNCE_CYCLES(4), .NUM_DIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor sampled on the inactive edge
    initial begin
        ks_cnt = 0; os_cnt = 0; ks_wide = 0; os_wide = 0;
        ks_prev = 1'b0; os_prev = 1'b0;
    end
    always @(negedge clk) begin
        if (bus.key_strobe) ks_cnt++;
        if (bus.op_strobe) os_cnt++;
        if (bus.key_strobe && ks_prev) ks_wide++;
        if (bus.op_strobe && os_prev) os_wide++;
        ks_prev = bus.key_strobe;
        os_prev = bus.op_strobe;
    end

    task automatic press_key(input logic [3:0] code);
        @(negedge clk);
        bus.key_code = code;
        bus.key_down = 1'b1;
        repeat (12) @(negedge clk);
        bus.key_down = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.key_down = 1'b0;
        bus.key_code = 4'h0;
        repeat (3) @(negedge clk);
        checks++; if (bus.key_strobe !== 1'b0) begin errors++; $display("FAIL reset_key_strobe: got %b expected 0", bus.key_strobe); end
        checks++; if (bus.entry !== 16'h0000) begin errors++; $display("FAIL reset_entry: got %h expected 0000", bus.entry); end
        checks++; if (bus.digit_count !== 3'd0) begin errors++; $display("FAIL reset_digit_count: got %0d expected 0", bus.digit_count); end
        checks++; if ({bus.key_val, bus.op_strobe, bus.op_code, bus.operand} !== 23'd0) begin errors++; $display("FAIL reset_others: key_val=%h op_strobe=%b op_code=%b operand=%h expected all 0", bus.key_val, bus.op_strobe, bus.op_code, bus.operand); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_latency();
        int first;
        int seen;
        logic [15:0] entry_at_strobe;
        first = 0; seen = 0; entry_at_strobe = 16'hxxxx;
        @(negedge clk);
        bus.key_code = 4'h5;
        bus.key_down = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (bus.key_strobe) begin
                seen++;
                if (first == 0) begin
                    first = k;
                    entry_at_strobe = bus.entry;
                end
            end
        end
        checks++; if (seen !== 1) begin errors++; $display("FAIL lat_strobe_count: got %0d expected 1", seen); end
        checks++; if (first !== 6) begin errors++; $display("FAIL lat_cycles: got %0d expected 6", first); end
        checks++; if (entry_at_strobe !== 16'h0005) begin errors++; $display("FAIL lat_entry_with_strobe: got %h expected 0005", entry_at_strobe); end
        checks++; if (bus.key_val !== 4'h5) begin errors++; $display("FAIL lat_key_val: got %h expected 5", bus.key_val); end
        checks++; if (bus.digit_count !== 3'd1) begin errors++; $display("FAIL lat_digit_count: got %0d expected 1", bus.digit_count); end
        bus.key_down = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_bounce_press();
        int base;
        base = ks_cnt;
        @(negedge clk);
        bus.key_code = 4'h8;
        for (int i = 0; i < 5; i++) begin
            bus.key_down = ~bus.key_down;
            repeat (2) @(negedge clk);
        end
        bus.key_down = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (ks_cnt - base !== 0) begin errors++; $display("FAIL bounce_strobes: got %0d expected 0", ks_cnt - base); end
        checks++; if (bus.entry !== 16'h0005) begin errors++; $display("FAIL bounce_entry: got %h expected 0005", bus.entry); end
        checks++; if (bus.digit_count !== 3'd1) begin errors++; $display("FAIL bounce_digit_count: got %0d expected 1", bus.digit_count); end
    endtask

    task automatic test_digits_full();
        int base;
        press_key(4'hA);
        checks++; if (bus.entry !== 16'h0000) begin errors++; $display("FAIL clear_entry: got %h expected 0000", bus.entry); end
        base = ks_cnt;
        press_key(4'h1);
        press_key(4'h2);
        press_key(4'h3);
        press_key(4'h4);
        press_key(4'h7);
        checks++; if (ks_cnt - base !== 5) begin errors++; $display("FAIL full_strobes: got %0d expected 5", ks_cnt - base); end
        checks++; if (bus.entry !== 16'h1234) begin errors++; $display("FAIL full_entry: got %h expected 1234", bus.entry); end
        checks++; if (bus.digit_count !== 3'd4) begin errors++; $display("FAIL full_digit_count: got %0d expected 4", bus.digit_count); end
        checks++; if (bus.key_val !== 4'h7) begin errors++; $display("FAIL full_key_val: got %h expected 7", bus.key_val); end
    endtask

    task automatic test_backspace_clear();
        press_key(4'hB);
        checks++; if (bus.entry !== 16'h0123) begin errors++; $display("FAIL bs_entry: got %h expected 0123", bus.entry); end
        checks++; if (bus.digit_count !== 3'd3) begin errors++; $display("FAIL bs_digit_count: got %0d expected 3", bus.digit_count); end
        press_key(4'hA);
        checks++; if (bus.entry !== 16'h0000) begin errors++; $display("FAIL clr_entry: got %h expected 0000", bus.entry); end
        checks++; if (bus.digit_count !== 3'd0) begin errors++; $display("FAIL clr_digit_count: got %0d expected 0", bus.digit_count); end
        press_key(4'hB);
        checks++; if (bus.entry !== 16'h0000) begin errors++; $display("FAIL bs_empty_entry: got %h expected 0000", bus.entry); end
        checks++; if (bus.digit_count !== 3'd0) begin errors++; $display("FAIL bs_empty_digit_count: got %0d expected 0", bus.digit_count); end
    endtask

    task automatic test_operator();
        int base;
        press_key(4'h4);
        press_key(4'h2);
        base = os_cnt;
        press_key(4'hE);
        checks++; if (os_cnt - base !== 1) begin errors++; $display("FAIL op_strobe_count: got %0d expected 1", os_cnt - base); end
        checks++; if (bus.operand !== 16'h0042) begin errors++; $display("FAIL op_operand: got %h expected 0042", bus.operand); end
        checks++; if (bus.op_code !== 2'b10) begin errors++; $display("FAIL op_code: got %b expected 10", bus.op_code); end
        checks++; if (bus.entry !== 16'h0000) begin errors++; $display("FAIL op_entry: got %h expected 0000", bus.entry); end
        checks++; if (bus.digit_count !== 3'd0) begin errors++; $display("FAIL op_digit_count: got %0d expected 0", bus.digit_count); end
    endtask

    task automatic test_release_bounce();
        int base;
        base = ks_cnt;
        @(negedge clk);
        bus.key_code = 4'h9;
        bus.key_down = 1'b1;
        repeat (10) @(negedge clk);
        bus.key_down = 1'b0;
        @(negedge clk);
        bus.key_down = 1'b1;
        repeat (10) @(negedge clk);
        bus.key_down = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (ks_cnt - base !== 1) begin errors++; $display("FAIL relbounce_strobes: got %0d expected 1", ks_cnt - base); end
        checks++; if (bus.entry !== 16'h0009) begin errors++; $display("FAIL relbounce_entry: got %h expected 0009", bus.entry); end
    endtask

    task automatic test_reset_mid_press();
        int first;
        @(negedge clk);
        bus.key_code = 4'h3;
        bus.key_down = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (dut.state_q !== 2'b01) begin errors++; $display("FAIL midrst_pre_state: got %b expected 01", dut.state_q); end
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.key_strobe, bus.key_val, bus.entry, bus.digit_count} !== 24'd0) begin errors++; $display("FAIL midrst_outputs: key_val=%h entry=%h digit_count=%0d expected 0", bus.key_val, bus.entry, bus.digit_count); end
        checks++; if ({bus.op_strobe, bus.op_code, bus.operand} !== 19'd0) begin errors++; $display("FAIL midrst_op_outputs: op_code=%b operand=%h expected 0", bus.op_code, bus.operand); end
        checks++; if (dut.state_q !== 2'b00) begin errors++; $display("FAIL midrst_state: got %b expected 00", dut.state_q); end
        // Key still held when reset releases: a fresh press
        @(negedge clk);
        rst_n = 1'b1;
        first = 0;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            if (bus.key_strobe && first == 0) first = k;
        end
        checks++; if (first !== 6) begin errors++; $display("FAIL held_rst_latency: got %0d expected 6", first); end
        checks++; if (bus.entry !== 16'h0003) begin errors++; $display("FAIL held_rst_entry: got %h expected 0003", bus.entry); end
        bus.key_down = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.key_down = 1'b0;
        bus.key_code = 4'h0;
        test_reset();
        test_latency();
        test_bounce_press();
        test_digits_full();
        test_backspace_clear();
        test_operator();
        test_release_bounce();
        test_reset_mid_press();
        checks++; if (ks_wide !== 0) begin errors++; $display("FAIL key_strobe_width: got %0d wide pulses expected 0", ks_wide); end
        checks++; if (os_wide !== 0) begin errors++; $display("FAIL op_strobe_width: got %0d wide pulses expected 0", os_wide); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
